uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

UART receiver with a small receive FIFO that drives the control FSM's `rx_data` / `rx_done` / `rd_en` command port. It converts the serial `rx` line into bytes using 8N1 framing with 16x oversampling. It buffers received bytes so the FSM can pop them at its own pace. It sits between the board's USB-UART pin and the FSM, beside the button debouncers, as a second command source.

## Interface

Parameters:
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line baud rate.
- `FIFO_DEPTH`, default 4: number of FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous serial line; idles high.
- `rd_en`  input  1  pop the FIFO head; ignored while empty.
- `rx_data`  output  8  FIFO head byte, show-ahead; forced to 8'h00 while empty.
- `rx_done`  output  1  FIFO non-empty, i.e. `rx_data` is valid.
- `fifo_full`  output  1  FIFO holds `FIFO_DEPTH` bytes.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  one-cycle pulse: a valid byte was dropped because the FIFO was full.

## Operation

- **Input synchronizer.** `rx` passes through a 2-FF synchronizer (`rx_s`). Both flops reset to 1.
- **Tick generator.**
  - `DIV = CLK_FREQ/(BAUD*16)`, integer floor (651 at the defaults).
  - The counter runs 0..DIV-1 and asserts `tick` for one cycle when it reaches DIV-1.
  - The counter free-runs in every state.
- **Receive FSM.** States are IDLE, START, DATA, STOP. A 4-bit counter `scnt` counts ticks and a 3-bit counter `bcnt` counts bits.
  - IDLE: when `rx_s`=0, go to START and clear `scnt`. The tick phase is not realigned, so start-edge jitter of up to one tick is acceptable.
  - START: on the tick where `scnt`=7 (mid start bit), go to DATA with `scnt` cleared if `rx_s`=0. Otherwise the low was a glitch: return to IDLE with no flags.
  - DATA: on the tick where `scnt`=15, shift `rx_s` into the MSB of the shift register, so bits arrive LSB first. Increment `bcnt`. After bit 7, go to STOP.
  - STOP: on the tick where `scnt`=15, sample `rx_s`:
    - `rx_s`=1: assert push for one cycle.
    - `rx_s`=0: pulse `frame_err` and discard the byte.
    - Either way, return to IDLE.
  - A line held low produces one `frame_err` per frame attempt. A new frame is detected only once the FSM is in IDLE.
- **FIFO.**
  - Circular buffer with read and write pointers of width log2(`FIFO_DEPTH`)+1; the extra bit distinguishes full from empty.
  - Push while full with no pop in the same cycle: byte dropped, `overrun` pulses.
  - Push and pop in the same cycle while full: both are performed, no overrun, occupancy unchanged.
  - Push and pop in the same cycle while empty: push performed, pop ignored, so `rx_done` rises.
  - `rd_en` while empty: no effect.
- **Widths.** All counters are unsigned. Pointers wrap modulo 2·`FIFO_DEPTH`.

## Timing

- **Reset values** (registered at the first rising edge with `reset`=1):
  - outputs: `rx_done`=0, `rx_data`=8'h00, `fifo_full`=0, `frame_err`=0, `overrun`=0;
  - internal: FSM in IDLE, FIFO empty, all counters 0.
- **Synchronizer latency.** An `rx` edge appears on `rx_s` 2 cycles later.
- **Receive latency.** Stop-bit sampling happens about 9.5 bit periods after the start edge.
  - The push is registered on the cycle after the stop-bit sample tick, and `rx_done` and `rx_data` update on that same edge.
  - With the defaults this is ≈ 9.5 × 10416 cycles after the falling start edge, ±1 tick.
- **Pop.** When `rd_en` is high at edge N and the FIFO is non-empty, `rx_data` shows the next entry after edge N. `rx_done` falls after edge N if that was the last entry.
- **Flag pulses.** `frame_err` and `overrun` are registered and high for exactly one cycle, on the cycle after the offending stop-bit sample tick.
- **Mid-operation reset.** Reset asserted mid-frame or mid-FIFO aborts the frame and empties the FIFO in the same cycle. The next frame is received normally only if its start edge arrives after reset deasserts.

## Structure

- **Shared package `uart_pkg`:**
  - the receive-state enum (IDLE/START/DATA/STOP);
  - `OVERSAMPLE`=16 and `MID_SAMPLE`=7;
  - the DIV calculation.
- **Sub-module `sync_fifo`:** parameterised by width (8) and depth, with ports `push`, `pop`, `din`, `dout`, `empty`, `full`, `drop`.
- **Top level:** synchronizer, tick generator and receive FSM live in `uart_rx_fifo`.

## Test plan

Sim parameters: `CLK_FREQ`=1_600_000, `BAUD`=100_000, giving DIV=1 and 16 cycles per bit.

1. **Single byte.** Send 8'hA5 (8N1) → `rx_done` rises 1 cycle after the stop sample with `rx_data`=8'hA5. Pulse `rd_en` → `rx_done`=0 and `rx_data`=8'h00.
2. **Fill to full.** Send 0x01,0x02,0x03,0x04 with no pops → `fifo_full`=1. Send 0x05 → `overrun` pulses once and the FIFO reads back 01,02,03,04 in order.
3. **Push and pop while full.** Assert `rd_en` on the exact push cycle of 0x05 while full → no overrun, contents 02,03,04,05.
4. **Bad stop bit.** Send 8'h3C with the stop bit low → `frame_err` pulses, `rx_done` stays 0. A following 8'h3C with a good stop bit is received.
5. **Glitch and reset.**
   - Pull `rx` low for 4 cycles → the FSM returns to IDLE with no push and no flags.
   - Assert `reset` mid-DATA while the FIFO holds 2 bytes → all outputs return to reset values, and the next frame 8'h7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: receive-state encoding,
// oversampling constants and the baud-tick divider calculation.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // Clock cycles per oversample tick, integer floor; never below 1.
    function automatic int calc_div(input int clk_freq, input int baud);
        int div;
        div = clk_freq / (baud * OVERSAMPLE);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with show-ahead output. Pointers carry one
// extra wrap bit so full and empty are distinguishable. A push while full
// is dropped (and flagged) unless a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    // Status flags, accepted operations and next pointer values.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        drop     = push && full && !do_pop;
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; only control state is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small show-ahead FIFO.
// The line is synchronised, sampled mid-bit by a tick-driven FSM, and good
// bytes are pushed into the FIFO the cycle after the stop-bit sample.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [3:0]    SCNT_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0]    SCNT_LAST = 4'(OVERSAMPLE - 1);

    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tick;
    rx_state_e     state_q, state_d;
    logic [3:0]    scnt_q, scnt_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          push;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          fifo_empty;
    logic          fifo_drop;

    // Two-stage synchroniser path and free-running tick divider.
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        tick      = (tcnt_q == TICK_LAST);
        tcnt_d    = tick ? '0 : tcnt_q + TW'(1);
    end

    // Synchroniser (idles high) and tick counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            tcnt_q    <= '0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            tcnt_q    <= tcnt_d;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Receive FSM next-state logic; a high line at mid start bit is a glitch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rx_s_q) state_d = ST_START;
            ST_START: if (tick && scnt_q == SCNT_MID)
                          state_d = rx_s_q ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick && scnt_q == SCNT_LAST && bcnt_q == 3'd7)
                          state_d = ST_STOP;
            ST_STOP:  if (tick && scnt_q == SCNT_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Receive FSM outputs: push a good byte or flag a low stop bit.
    always_comb begin
        push        = 1'b0;
        frame_err_d = 1'b0;
        if (state_q == ST_STOP && tick && scnt_q == SCNT_LAST) begin
            push        = rx_s_q;
            frame_err_d = !rx_s_q;
        end
        overrun_d = fifo_drop;
    end

    // Sample and bit counters plus the LSB-first shift register.
    always_comb begin
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                scnt_d = '0;
                bcnt_d = '0;
            end
            ST_START: begin
                if (tick) scnt_d = (scnt_q == SCNT_MID) ? '0 : scnt_q + 4'd1;
            end
            ST_DATA: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == SCNT_LAST) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bcnt_d  = bcnt_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) scnt_d = scnt_q + 4'd1;
            end
            default: begin
                scnt_d = '0;
                bcnt_d = '0;
            end
        endcase
    end

    // Counter and flag registers; the shift register holds data only.
    always_ff @(posedge clk) begin
        if (reset) begin
            scnt_q      <= '0;
            bcnt_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            scnt_q      <= scnt_d;
            bcnt_q      <= bcnt_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
        shift_q <= shift_d;
    end

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .din   (shift_q),
        .dout  (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .drop  (fifo_drop)
    );

    assign rx_done   = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at 16 clocks per bit: directed scenarios plus a
// randomized run checked against a queue model of the receive FIFO.
module tb_uart_rx_fifo;

    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       fifo_full;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int rise_cyc = -1;
    logic done_prev = 1'b0;
    int start_cyc = 0;

    uart_rx_fifo #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_en     (rd_en),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .fifo_full (fifo_full),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Pulse counters and rx_done rise time, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (rx_done && !done_prev) rise_cyc <= cyc;
        done_prev <= rx_done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serialise one 8N1 frame; rd_en is raised for the edge pop_at+1
    // counted from the start of the start bit (-1: never).
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int pop_at);
        logic [9:0] bits;
        int c;
        bits = {stop_ok, b, 1'b0};
        c = 0;
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int k = 0; k < CPB; k++) begin
                rd_en = (c == pop_at);
                step();
                c++;
            end
        end
        rx = 1'b1;
        rd_en = 1'b0;
        repeat (4) step();
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        rd_en = 1'b0;
        repeat (3) step();
        n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_full: got %b want 0", fifo_full); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        reset = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_single();
        int f0;
        int lat;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, -1);
        // Stop sample sits 9.5 bits (152 cycles) in; add the synchroniser
        // and idle detection delay, allowing a few cycles of slack.
        lat = rise_cyc - start_cyc;
        n_cmp++; if (lat < 152 || lat > 158) begin n_bad++; $display("FAIL single_latency: got %0d want 152..158", lat); end
        n_cmp++; if (rx_done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b want 1", rx_done); end
        n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", rx_data); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0); end
        pulse_rd();
        n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL single_pop_done: got %b want 0", rx_done); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL single_pop_data: got %h want 00", rx_data); end
    endtask

    task automatic test_fill();
        int o0;
        logic [7:0] exp;
        o0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1);
        n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", fifo_full); end
        send_frame(8'h05, 1'b1, -1);
        n_cmp++; if (ovr_cnt - o0 !== 1) begin n_bad++; $display("FAIL fill_overrun: got %0d want 1", ovr_cnt - o0); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            n_cmp++; if (rx_data !== exp) begin n_bad++; $display("FAIL fill_read%0d: got %h want %h", i, rx_data, exp); end
            pulse_rd();
        end
        n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL fill_drained: got %b want 0", rx_done); end
    endtask

    task automatic test_push_pop_full();
        int o0;
        logic [7:0] exp;
        o0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1);
        // Push lands on edge 155 of the frame: 2 sync + 1 detect + 8 start
        // + 8*16 data + 16 stop cycles.
        send_frame(8'h05, 1'b1, 154);
        n_cmp++; if (ovr_cnt - o0 !== 0) begin n_bad++; $display("FAIL ppf_overrun: got %0d want 0", ovr_cnt - o0); end
        n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL ppf_full: got %b want 1", fifo_full); end
        for (int i = 2; i <= 5; i++) begin
            exp = 8'(i);
            n_cmp++; if (rx_data !== exp) begin n_bad++; $display("FAIL ppf_read%0d: got %h want %h", i, rx_data, exp); end
            pulse_rd();
        end
        n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL ppf_drained: got %b want 0", rx_done); end
    endtask

    task automatic test_bad_stop();
        int f0;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1);
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_bad++; $display("FAIL badstop_ferr: got %0d want 1", ferr_cnt - f0); end
        n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL badstop_done: got %b want 0", rx_done); end
        send_frame(8'h3C, 1'b1, -1);
        n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL badstop_good_data: got %h want 3c", rx_data); end
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_bad++; $display("FAIL badstop_good_ferr: got %0d want 1", ferr_cnt - f0); end
        pulse_rd();
    endtask

    task automatic test_glitch_and_reset();
        int f0;
        int o0;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rx = 1'b0;
        repeat (4) step();
        rx = 1'b1;
        repeat (40) step();
        n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL glitch_done: got %b want 0", rx_done); end
        n_cmp++; if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin n_bad++; $display("FAIL glitch_flags: got %0d want 0", (ferr_cnt - f0) + (ovr_cnt - o0)); end
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        n_cmp++; if (rx_data !== 8'h11) begin n_bad++; $display("FAIL midrst_pre_data: got %h want 11", rx_data); end
        // Start a frame and abort it with reset partway through the data bits.
        rx = 1'b0;
        repeat (CPB) step();
        rx = 1'b1;
        repeat (CPB * 3) step();
        rx = 1'b0;
        repeat (CPB) step();
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) step();
        n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", rx_done); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL midrst_data: got %h want 00", rx_data); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL midrst_full: got %b want 0", fifo_full); end
        n_cmp++; if ({frame_err, overrun} !== 2'b00) begin n_bad++; $display("FAIL midrst_flags: got %b want 00", {frame_err, overrun}); end
        reset = 1'b0;
        repeat (5) step();
        f0 = ferr_cnt;
        send_frame(8'h7E, 1'b1, -1);
        n_cmp++; if (rx_data !== 8'h7E) begin n_bad++; $display("FAIL midrst_next_data: got %h want 7e", rx_data); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL midrst_next_ferr: got %0d want 0", ferr_cnt - f0); end
        pulse_rd();
        n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL midrst_next_empty: got %b want 0", rx_done); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] b;
        logic [7:0] exp;
        logic good;
        int f0;
        int o0;
        int exp_f;
        int exp_o;
        int npop;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        exp_f = 0;
        exp_o = 0;
        for (int n = 0; n < 14; n++) begin
            b = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good, -1);
            if (!good) exp_f++;
            else if (q.size() == FIFO_DEPTH) exp_o++;
            else q.push_back(b);
            n_cmp++; if (fifo_full !== (q.size() == FIFO_DEPTH)) begin n_bad++; $display("FAIL rand_full[%0d]: got %b want %b", n, fifo_full, q.size() == FIFO_DEPTH); end
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) begin
                exp = (q.size() != 0) ? q[0] : 8'h00;
                n_cmp++; if (rx_done !== (q.size() != 0)) begin n_bad++; $display("FAIL rand_done[%0d]: got %b want %b", n, rx_done, q.size() != 0); end
                n_cmp++; if (rx_data !== exp) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", n, rx_data, exp); end
                pulse_rd();
                if (q.size() != 0) void'(q.pop_front());
            end
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (q.size() != 0) begin
                exp = q.pop_front();
                n_cmp++; if (rx_data !== exp) begin n_bad++; $display("FAIL rand_drain: got %h want %h", rx_data, exp); end
                pulse_rd();
            end
        end
        n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL rand_empty: got %b want 0", rx_done); end
        n_cmp++; if (ferr_cnt - f0 !== exp_f) begin n_bad++; $display("FAIL rand_ferr: got %0d want %0d", ferr_cnt - f0, exp_f); end
        n_cmp++; if (ovr_cnt - o0 !== exp_o) begin n_bad++; $display("FAIL rand_overrun: got %0d want %0d", ovr_cnt - o0, exp_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_push_pop_full();
        test_bad_stop();
        test_glitch_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
